pipelined_barrel_shifter: RTL and testbench

//  Parametrised, pipelined barrel shifter: successor to the fixed 4-bit mux-tree shifter stages.

---
 rtl/pipelined_barrel_shifter_if.sv | 27 ++
 rtl/pipelined_barrel_shifter.sv | 134 +++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_barrel_shifter_if.sv
// Operand/result handshake bundle for pipelined_barrel_shifter.
// The slave side is the shifter. The master side is the producer/consumer driving it.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 16
);
    localparam int LOG2W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LOG2W-1:0] in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_carry
    );

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_carry
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined LSL/LSR/ASR/ROR barrel shifter: one registered mux level per shift-amount bit, valid/ready on both sides.
// Define BSHIFT_CARRY_EN to produce out_carry (last bit shifted out); otherwise out_carry is tied to 0.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 16
) (
    input logic                       clk,
    input logic                       rst_n,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int LOG2W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [LOG2W-1:0] amt;
        mode_e            mode;
        logic             sign;
`ifdef BSHIFT_CARRY_EN
        logic             carry;
`endif
    } word_t;

    // One mux level: shift by sh when active. The carry becomes the last bit this level drops.
    function automatic word_t shiftLevel(input word_t w, input logic active, input int sh);
        word_t            r;
        logic [WIDTH-1:0] fill;
        r    = w;
        fill = w.sign ? ~({WIDTH{1'b1}} >> sh) : '0;
        if (active) begin
            case (w.mode)
                MODE_LSL: r.data = w.data << sh;
                MODE_LSR: r.data = w.data >> sh;
                MODE_ASR: r.data = (w.data >> sh) | fill;
                default:  r.data = (w.data >> sh) | (w.data << (WIDTH - sh));
            endcase
`ifdef BSHIFT_CARRY_EN
            case (w.mode)
                MODE_LSL: r.carry = w.data[LOG2W'(WIDTH - sh)];
                MODE_ROR: r.carry = 1'b0;
                default:  r.carry = w.data[LOG2W'(sh - 1)];
            endcase
`endif
        end
        return r;
    endfunction

    word_t            headWord;
    word_t            stageIn  [LOG2W];
    word_t            stageOut [LOG2W];
    logic             validIn  [LOG2W];
    word_t            stage_q  [LOG2W-1];
    logic             valid_q  [LOG2W-1];
    logic [WIDTH-1:0] outData_q;
    logic             outValid_q;
    logic             stall;

    // A held result freezes the whole pipe, so nothing is accepted or overwritten.
    assign stall         = outValid_q && !bus.out_ready;
    assign bus.in_ready  = !stall;
    assign bus.out_valid = outValid_q;
    assign bus.out_data  = outData_q;

    always_comb begin
        headWord      = '0;
        headWord.data = bus.in_data;
        headWord.amt  = bus.in_amt;
        headWord.mode = mode_e'(bus.in_mode);
        headWord.sign = bus.in_data[WIDTH-1];
    end

    for (genvar k = 0; k < LOG2W; k++) begin : g_level
        localparam int SH = 1 << k;

        if (k == 0) begin : g_head
            assign stageIn[k] = headWord;
            assign validIn[k] = bus.in_valid;
        end else begin : g_chain
            assign stageIn[k] = stage_q[k-1];
            assign validIn[k] = valid_q[k-1];
        end

        assign stageOut[k] = shiftLevel(stageIn[k], stageIn[k].amt[k], SH);

        // Bubbles advance but never overwrite the stage payload.
        if (k < LOG2W - 1) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q[k] <= 1'b0;
                    stage_q[k] <= '0;
                end else if (!stall) begin
                    valid_q[k] <= validIn[k];
                    if (validIn[k]) begin
                        stage_q[k] <= stageOut[k];
                    end
                end
            end
        end
    end

    // out_data keeps the last result while the output slot is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
        end else if (!stall) begin
            outValid_q <= validIn[LOG2W-1];
            if (validIn[LOG2W-1]) begin
                outData_q <= stageOut[LOG2W-1].data;
            end
        end
    end

`ifdef BSHIFT_CARRY_EN
    logic outCarry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outCarry_q <= 1'b0;
        end else if (!stall && validIn[LOG2W-1]) begin
            outCarry_q <= stageOut[LOG2W-1].carry;
        end
    end

    assign bus.out_carry = outCarry_q;
`else
    assign bus.out_carry = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=16): directed vector table plus stall, reset and random streams.
// Carry expectations follow BSHIFT_CARRY_EN; without it out_carry must stay 0.
module tb_pipelined_barrel_shifter;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   testCount = 0;
    int   failCount = 0;

    pipelined_barrel_shifter_if #(.WIDTH(WIDTH)) bus ();

    pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  amt;
        logic [1:0]  mode;
        logic [15:0] expData;
        logic        expCarry;
    } vec_t;

    vec_t vecs [15];

    function automatic logic carryExp(input logic c);
`ifdef BSHIFT_CARRY_EN
        return c;
`else
        return 1'b0 & c;
`endif
    endfunction

    // Reference result {carry, data}, written with whole-word operators.
    function automatic logic [16:0] model(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m);
        logic [15:0] r;
        logic        c;
        int          n;
        n = int'(a);
        c = 1'b0;
        case (m)
            2'b00: begin r = d << n; if (n > 0) c = d[16 - n]; end
            2'b01: begin r = d >> n; if (n > 0) c = d[n - 1]; end
            2'b10: begin r = $signed(d) >>> n; if (n > 0) c = d[n - 1]; end
            default: r = (d >> n) | (d << (16 - n));
        endcase
        return {carryExp(c), r};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_mode  = m;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Per-cycle driver/monitor; scenario 0 is the 8-word stall pattern, scenario 1 is random traffic.
    task automatic runStream(input int nWords, input bit randomMode);
        logic [16:0] expQ [$];
        logic [16:0] e;
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        bit          holdWord = 1'b0;
        while ((got < nWords) && (cyc < nWords * 8 + 50)) begin
            @(negedge clk);
            if (!holdWord) begin
                if ((sent < nWords) && (!randomMode || ($urandom_range(0, 9) < 6))) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = 16'($urandom);
                    bus.in_amt   = 4'($urandom);
                    bus.in_mode  = 2'($urandom);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = randomMode ? ($urandom_range(0, 9) < 7) : !((cyc >= 6) && (cyc <= 9));
            #1;
            if (!randomMode && (cyc >= 5) && (cyc <= 10)) begin
                checkOutput($sformatf("stall_in_ready_c%0d", cyc), 32'(bus.in_ready),
                            32'(!((cyc >= 6) && (cyc <= 9))));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("extra_output", 32'(1), 32'(0));
                end else begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("stream_word_%0d", got), 32'({bus.out_carry, bus.out_data}), 32'(e));
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                expQ.push_back(model(bus.in_data, bus.in_amt, bus.in_mode));
                sent++;
                holdWord = 1'b0;
            end else begin
                holdWord = bus.in_valid;
            end
            cyc++;
        end
        checkOutput("stream_words_received", 32'(got), 32'(nWords));
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cycles;
        int stale;

        vecs[0]  = '{16'h0001, 4'd15, 2'b00, 16'h8000, 1'b0};
        vecs[1]  = '{16'h8000, 4'd4,  2'b10, 16'hF800, 1'b0};
        vecs[2]  = '{16'h8000, 4'd4,  2'b01, 16'h0800, 1'b0};
        vecs[3]  = '{16'h0001, 4'd1,  2'b11, 16'h8000, 1'b0};
        vecs[4]  = '{16'h1234, 4'd0,  2'b11, 16'h1234, 1'b0};
        vecs[5]  = '{16'hC000, 4'd1,  2'b00, 16'h8000, 1'b1};
        vecs[6]  = '{16'h0009, 4'd4,  2'b01, 16'h0000, 1'b1};
        vecs[7]  = '{16'h7FF0, 4'd3,  2'b10, 16'h0FFE, 1'b0};
        vecs[8]  = '{16'hA5A5, 4'd0,  2'b10, 16'hA5A5, 1'b0};
        vecs[9]  = '{16'h1234, 4'd4,  2'b11, 16'h4123, 1'b0};
        vecs[10] = '{16'h1234, 4'd4,  2'b00, 16'h2340, 1'b1};
        vecs[11] = '{16'h8001, 4'd15, 2'b10, 16'hFFFF, 1'b0};
        vecs[12] = '{16'hFFFF, 4'd15, 2'b01, 16'h0001, 1'b1};
        vecs[13] = '{16'h8001, 4'd15, 2'b11, 16'h0003, 1'b0};
        vecs[14] = '{16'hFFFF, 4'd0,  2'b00, 16'hFFFF, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b1;

        @(negedge clk);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'(0));
        checkOutput("reset_out_data",  32'(bus.out_data),  32'(0));
        checkOutput("reset_out_carry", 32'(bus.out_carry), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'(1));

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].data, vecs[i].amt, vecs[i].mode);
            cycles = 1;
            while (!bus.out_valid && (cycles < 16)) begin
                @(negedge clk);
                cycles++;
            end
            checkOutput($sformatf("vec%0d_latency", i), 32'(cycles), 32'(4));
            checkOutput($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(vecs[i].expData));
            checkOutput($sformatf("vec%0d_carry", i), 32'(bus.out_carry), 32'(carryExp(vecs[i].expCarry)));
        end
        @(negedge clk);
        @(negedge clk);
        checkOutput("idle_out_valid", 32'(bus.out_valid), 32'(0));
        checkOutput("idle_out_data_held", 32'(bus.out_data), 32'(16'hFFFF));

        runStream(8, 1'b0);

        // Three words in flight with the first one held at the output, then an async reset between edges.
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h1000 + 16'(i);
            bus.in_amt   = 4'(i + 1);
            bus.in_mode  = 2'b00;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        cycles = 0;
        while (!bus.out_valid && (cycles < 10)) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("flush_precondition_out_valid", 32'(bus.out_valid), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("flush_out_valid_async", 32'(bus.out_valid), 32'(0));
        checkOutput("flush_out_data_cleared", 32'(bus.out_data), 32'(0));
        checkOutput("flush_in_ready", 32'(bus.in_ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        checkOutput("flush_no_stale_results", 32'(stale), 32'(0));

        runStream(10000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
